// File: rtl/ptp_bus_sequencer.sv
// ptp_bus_sequencer
// Sequences one core memory request over the byte-wide host bus: sends a
// command byte, then four data bytes, one host ack edge per byte. Reads
// strobe the ptp_a deserialiser; writes step the ptp_b serialiser. A
// per-byte timeout aborts a stalled transfer.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_valid_i/write/addr    core request (held until req_ready_o)
//   req_ready_o               1-cycle pulse, request accepted
//   rsp_valid_o               1-cycle pulse, transfer complete
//   timeout_o                 sticky abort flag, cleared by next request
//   busy_o                    high whenever not idle
//   host_cmd_o/_valid_o       command byte {write, 2'b00, addr}
//   out_sel_o                 host data source: 0 = command, 1 = ptp_b
//   host_ack_i                host byte strobe, rising edge = one byte
//   byte_idx_o                current data byte 0..3
//   ptp_a_control_o/reset_o   strobe / clear for ptp_a
//   ptp_b_control_o/reset_o   advance / rewind for ptp_b
module ptp_bus_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    input  logic       req_write_i,
    input  logic [4:0] req_addr_i,
    output logic       req_ready_o,
    output logic       rsp_valid_o,
    output logic       timeout_o,
    output logic       busy_o,
    output logic [7:0] host_cmd_o,
    output logic       host_cmd_valid_o,
    output logic       out_sel_o,
    input  logic       host_ack_i,
    output logic [1:0] byte_idx_o,
    output logic       ptp_a_control_o,
    output logic       ptp_a_reset_o,
    output logic       ptp_b_control_o,
    output logic       ptp_b_reset_o
);

    localparam int unsigned     CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic              ack_q;
    logic              is_write;
    logic [CNT_W-1:0]  cnt;
    logic              ack_edge;
    logic              expired;

    assign ack_edge = host_ack_i & ~ack_q;
    assign expired  = (cnt == CNT_LAST);

    // Single-process FSM; every output is a register updated here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= S_IDLE;
            ack_q            <= 1'b0;
            is_write         <= 1'b0;
            cnt              <= '0;
            req_ready_o      <= 1'b0;
            rsp_valid_o      <= 1'b0;
            timeout_o        <= 1'b0;
            busy_o           <= 1'b0;
            host_cmd_o       <= '0;
            host_cmd_valid_o <= 1'b0;
            out_sel_o        <= 1'b0;
            byte_idx_o       <= '0;
            ptp_a_control_o  <= 1'b0;
            ptp_a_reset_o    <= 1'b0;
            ptp_b_control_o  <= 1'b0;
            ptp_b_reset_o    <= 1'b0;
        end else begin
            ack_q           <= host_ack_i;
            req_ready_o     <= 1'b0;
            rsp_valid_o     <= 1'b0;
            ptp_a_control_o <= 1'b0;
            ptp_a_reset_o   <= 1'b0;
            ptp_b_control_o <= 1'b0;
            ptp_b_reset_o   <= 1'b0;

            case (state)
                S_IDLE: begin
                    // The rsp_valid cycle still belongs to the finished
                    // transfer, so no request is taken while it is high.
                    if (req_valid_i && !rsp_valid_o) begin
                        is_write         <= req_write_i;
                        host_cmd_o       <= {req_write_i, 2'b00, req_addr_i};
                        host_cmd_valid_o <= 1'b1;
                        out_sel_o        <= 1'b0;
                        req_ready_o      <= 1'b1;
                        timeout_o        <= 1'b0;
                        busy_o           <= 1'b1;
                        cnt              <= '0;
                        ptp_a_reset_o    <= ~req_write_i;
                        ptp_b_reset_o    <= req_write_i;
                        state            <= S_CMD;
                    end
                end

                S_CMD: begin
                    if (ack_edge) begin
                        cnt              <= '0;
                        byte_idx_o       <= '0;
                        host_cmd_valid_o <= 1'b0;
                        out_sel_o        <= is_write;
                        state            <= is_write ? S_WR : S_RD;
                    end else if (expired) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Byte 0 is already presented by ptp_b, so only three advances.
                S_WR: begin
                    if (ack_edge) begin
                        cnt <= '0;
                        if (byte_idx_o == 2'd3) begin
                            state <= S_DONE;
                        end else begin
                            ptp_b_control_o <= 1'b1;
                            byte_idx_o      <= byte_idx_o + 2'd1;
                        end
                    end else if (expired) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Every read byte, including the last, is strobed into ptp_a.
                S_RD: begin
                    if (ack_edge) begin
                        cnt             <= '0;
                        ptp_a_control_o <= 1'b1;
                        if (byte_idx_o == 2'd3) begin
                            state <= S_DONE;
                        end else begin
                            byte_idx_o <= byte_idx_o + 2'd1;
                        end
                    end else if (expired) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    rsp_valid_o <= 1'b1;
                    busy_o      <= 1'b0;
                    out_sel_o   <= 1'b0;
                    state       <= S_IDLE;
                end

                S_ERR: begin
                    timeout_o        <= 1'b1;
                    ptp_a_reset_o    <= 1'b1;
                    ptp_b_reset_o    <= 1'b1;
                    busy_o           <= 1'b0;
                    out_sel_o        <= 1'b0;
                    host_cmd_valid_o <= 1'b0;
                    state            <= S_IDLE;
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptp_bus_sequencer.sv
// Directed bench for ptp_bus_sequencer (TIMEOUT_CYCLES = 8): read, write,
// back-to-back spacing, timeout, ack held high, reset mid-transfer and
// ack edge against timeout limit.
module tb_ptp_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [4:0] req_addr = 5'd0;
    logic       req_ready;
    logic       rsp_valid;
    logic       timeout;
    logic       busy;
    logic [7:0] host_cmd;
    logic       host_cmd_valid;
    logic       out_sel;
    logic       host_ack = 1'b0;
    logic [1:0] byte_idx;
    logic       ptp_a_control;
    logic       ptp_a_reset;
    logic       ptp_b_control;
    logic       ptp_b_reset;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_cnt = 0;
    int b_cnt = 0;
    int overlap = 0;
    int rsp_cyc = 0;
    int ready_cyc = 0;

    ptp_bus_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .req_valid_i     (req_valid),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_ready_o     (req_ready),
        .rsp_valid_o     (rsp_valid),
        .timeout_o       (timeout),
        .busy_o          (busy),
        .host_cmd_o      (host_cmd),
        .host_cmd_valid_o(host_cmd_valid),
        .out_sel_o       (out_sel),
        .host_ack_i      (host_ack),
        .byte_idx_o      (byte_idx),
        .ptp_a_control_o (ptp_a_control),
        .ptp_a_reset_o   (ptp_a_reset),
        .ptp_b_control_o (ptp_b_control),
        .ptp_b_reset_o   (ptp_b_reset)
    );

    always #5 clk = ~clk;

    // Advance one cycle and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ptp_a_control) a_cnt++;
        if (ptp_b_control) b_cnt++;
        if ((ptp_a_control | ptp_b_control) & (ptp_a_reset | ptp_b_reset)) overlap++;
        if (rsp_valid) rsp_cyc = cyc;
    endtask

    task automatic ack_hi();
        host_ack = 1'b1;
        tick();
    endtask

    task automatic ack_lo();
        host_ack = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out_sel"}, 32'(out_sel), 32'd0);
        chk({tag, "_host_cmd"}, 32'(host_cmd), 32'd0);
        chk({tag, "_cmd_valid"}, 32'(host_cmd_valid), 32'd0);
        chk({tag, "_byte_idx"}, 32'(byte_idx), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_a_ctl"}, 32'(ptp_a_control), 32'd0);
        chk({tag, "_a_rst"}, 32'(ptp_a_reset), 32'd0);
        chk({tag, "_b_ctl"}, 32'(ptp_b_control), 32'd0);
        chk({tag, "_b_rst"}, 32'(ptp_b_reset), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_reset("rst");
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Read of address 0x13
        a_cnt = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h13;
        tick();
        ready_cyc = cyc;
        chk("rd_req_ready", 32'(req_ready), 32'd1);
        chk("rd_a_reset", 32'(ptp_a_reset), 32'd1);
        chk("rd_b_reset", 32'(ptp_b_reset), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_host_cmd", 32'(host_cmd), 32'h13);
        chk("rd_cmd_valid", 32'(host_cmd_valid), 32'd1);
        req_valid = 1'b0;
        ack_hi();
        chk("rd_cmd_done", 32'(host_cmd_valid), 32'd0);
        chk("rd_idx0", 32'(byte_idx), 32'd0);
        chk("rd_no_strobe_cmd", 32'(ptp_a_control), 32'd0);
        chk("rd_out_sel", 32'(out_sel), 32'd0);
        chk("rd_ready_width", 32'(req_ready), 32'd0);
        ack_lo();
        for (int i = 1; i <= 3; i++) begin
            ack_hi();
            chk("rd_strobe", 32'(ptp_a_control), 32'd1);
            chk("rd_idx", 32'(byte_idx), 32'(i));
            ack_lo();
            chk("rd_strobe_width", 32'(ptp_a_control), 32'd0);
        end
        ack_hi();
        chk("rd_last_strobe", 32'(ptp_a_control), 32'd1);
        chk("rd_idx3_hold", 32'(byte_idx), 32'd3);
        chk("rd_done_busy", 32'(busy), 32'd1);
        chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
        ack_lo();
        chk("rd_rsp", 32'(rsp_valid), 32'd1);
        chk("rd_busy_fall", 32'(busy), 32'd0);
        chk("rd_latency", 32'(rsp_cyc - ready_cyc), 32'd10);
        chk("rd_strobe_count", 32'(a_cnt), 32'd4);
        tick();
        chk("rd_rsp_width", 32'(rsp_valid), 32'd0);

        // Write of address 0x1F, next request held from the DONE cycle
        b_cnt = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h1F;
        tick();
        chk("wr_req_ready", 32'(req_ready), 32'd1);
        chk("wr_b_reset", 32'(ptp_b_reset), 32'd1);
        chk("wr_a_reset", 32'(ptp_a_reset), 32'd0);
        chk("wr_host_cmd", 32'(host_cmd), 32'h9F);
        req_valid = 1'b0;
        ack_hi();
        chk("wr_out_sel", 32'(out_sel), 32'd1);
        chk("wr_idx0", 32'(byte_idx), 32'd0);
        chk("wr_no_step_cmd", 32'(ptp_b_control), 32'd0);
        ack_lo();
        for (int i = 1; i <= 3; i++) begin
            ack_hi();
            chk("wr_step", 32'(ptp_b_control), 32'd1);
            chk("wr_idx", 32'(byte_idx), 32'(i));
            chk("wr_out_sel_data", 32'(out_sel), 32'd1);
            ack_lo();
        end
        ack_hi();
        chk("wr_last_no_step", 32'(ptp_b_control), 32'd0);
        chk("wr_done_busy", 32'(busy), 32'd1);
        chk("wr_idx3_hold", 32'(byte_idx), 32'd3);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h00;
        ack_lo();
        chk("wr_rsp", 32'(rsp_valid), 32'd1);
        chk("wr_busy_fall", 32'(busy), 32'd0);
        chk("wr_out_sel_idle", 32'(out_sel), 32'd0);
        chk("wr_no_ready_done", 32'(req_ready), 32'd0);
        chk("wr_step_count", 32'(b_cnt), 32'd3);
        tick();
        chk("b2b_no_ready_rsp", 32'(req_ready), 32'd0);
        tick();
        chk("b2b_ready", 32'(req_ready), 32'd1);
        chk("b2b_host_cmd", 32'(host_cmd), 32'h00);
        chk("b2b_a_reset", 32'(ptp_a_reset), 32'd1);
        req_valid = 1'b0;

        // Timeout after two data bytes
        ack_hi();
        ack_lo();
        ack_hi();
        ack_lo();
        ack_hi();
        chk("to_idx2", 32'(byte_idx), 32'd2);
        ack_lo();
        repeat (7) tick();
        chk("to_not_yet", 32'(timeout), 32'd0);
        chk("to_err_busy", 32'(busy), 32'd1);
        tick();
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_a_reset", 32'(ptp_a_reset), 32'd1);
        chk("to_b_reset", 32'(ptp_b_reset), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_cmd_valid", 32'(host_cmd_valid), 32'd0);
        tick();
        chk("to_resets_width", 32'(ptp_a_reset | ptp_b_reset), 32'd0);
        chk("to_sticky", 32'(timeout), 32'd1);

        // New request clears the flag; ack edge exactly at the limit wins
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h13;
        tick();
        chk("to_clear", 32'(timeout), 32'd0);
        chk("edge_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        repeat (7) tick();
        ack_hi();
        chk("edge_wins_cmd", 32'(host_cmd_valid), 32'd0);
        chk("edge_wins_idx", 32'(byte_idx), 32'd0);
        ack_lo();
        chk("edge_wins_no_to", 32'(timeout), 32'd0);
        chk("edge_wins_busy", 32'(busy), 32'd1);

        // Reset during read byte 2, ack rising and held across release
        ack_hi();
        ack_lo();
        ack_hi();
        chk("mid_idx2", 32'(byte_idx), 32'd2);
        ack_lo();
        reset = 1'b1;
        host_ack = 1'b1;
        tick();
        check_reset("mid_rst");
        tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("held_idle", 32'(busy), 32'd0);
        chk("held_no_ready", 32'(req_ready), 32'd0);

        // Request while ack is still high: no progress until a fresh edge
        a_cnt = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h05;
        tick();
        chk("held_req_ready", 32'(req_ready), 32'd1);
        chk("held_host_cmd", 32'(host_cmd), 32'h05);
        req_valid = 1'b0;
        repeat (4) tick();
        chk("held_stuck_cmd", 32'(host_cmd_valid), 32'd1);
        ack_lo();
        ack_hi();
        chk("held_one_adv", 32'(host_cmd_valid), 32'd0);
        chk("held_idx0", 32'(byte_idx), 32'd0);
        tick();
        tick();
        chk("held_still_idx0", 32'(byte_idx), 32'd0);
        chk("held_no_strobe", 32'(a_cnt), 32'd0);
        ack_lo();
        for (int i = 1; i <= 3; i++) begin
            ack_hi();
            chk("post_rst_idx", 32'(byte_idx), 32'(i));
            ack_lo();
        end
        ack_hi();
        chk("post_rst_last", 32'(ptp_a_control), 32'd1);
        ack_lo();
        chk("post_rst_rsp", 32'(rsp_valid), 32'd1);
        chk("post_rst_count", 32'(a_cnt), 32'd4);
        chk("post_rst_no_to", 32'(timeout), 32'd0);

        chk("ctl_reset_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
